// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - double-buffered pixel store with frame-boundary bank swap and optional back-bank clear
module frame_buffer_ctrl #(
   parameter int               COL_BITS      = 7,
   parameter int               ROW_BITS      = 6,
   parameter int               PIX_W         = 12,
   parameter int               CLEAR_ON_SWAP = 1,
   parameter logic [PIX_W-1:0] CLEAR_COLOR   = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [COL_BITS-1:0] wr_col,
   input  logic [ROW_BITS-1:0] wr_row,
   input  logic [PIX_W-1:0]    wr_data,
   input  logic                wr_frame_done,
   output logic                wr_ready,
   input  logic                rd_en,
   input  logic [COL_BITS-1:0] rd_col,
   input  logic [ROW_BITS-1:0] rd_row,
   output logic [PIX_W-1:0]    rd_data,
   output logic                rd_valid,
   input  logic                frame_sync,
   output logic                front_sel,
   output logic [15:0]         frame_count,
   output logic                drop_err
);

   localparam int AW    = COL_BITS + ROW_BITS;
   localparam int DEPTH = 1 << AW;

   typedef enum logic [1:0] {ST_WRITE, ST_PENDING, ST_CLEAR} state_t;

   state_t            state_q, state_d;
   logic              front_sel_q, front_sel_d;
   logic [15:0]       frame_count_q, frame_count_d;
   logic [AW-1:0]     clr_cnt_q, clr_cnt_d;
   logic              drop_err_q, drop_err_d;
   logic [PIX_W-1:0]  rd_data_q;
   logic              rd_valid_q;
   logic              swap;

   logic [PIX_W-1:0]  bank0 [DEPTH];
   logic [PIX_W-1:0]  bank1 [DEPTH];

   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [PIX_W-1:0]  mem_wdata;
   logic [AW-1:0]     rd_addr;

   assign wr_ready    = (state_q == ST_WRITE);
   assign rd_data     = rd_data_q;
   assign rd_valid    = rd_valid_q;
   assign front_sel   = front_sel_q;
   assign frame_count = frame_count_q;
   assign drop_err    = drop_err_q;

   always_comb begin
      state_d       = state_q;
      front_sel_d   = front_sel_q;
      frame_count_d = frame_count_q;
      clr_cnt_d     = clr_cnt_q;
      swap          = 1'b0;
      drop_err_d    = drop_err_q | (wr_en & ~wr_ready);
      case (state_q)
         ST_WRITE: begin
            if (wr_frame_done) begin
               if (frame_sync) swap = 1'b1;
               else            state_d = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (frame_sync) swap = 1'b1;
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (wr_frame_done) drop_err_d = 1'b1;
            if (clr_cnt_q == '1) state_d = ST_WRITE;
         end
         default: state_d = ST_WRITE;
      endcase
      if (swap) begin
         front_sel_d   = ~front_sel_q;
         frame_count_d = frame_count_q + 16'd1;
         clr_cnt_d     = '0;
         state_d       = (CLEAR_ON_SWAP != 0) ? ST_CLEAR : ST_WRITE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_WRITE;
         front_sel_q   <= 1'b0;
         frame_count_q <= '0;
         clr_cnt_q     <= '0;
         drop_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         front_sel_q   <= front_sel_d;
         frame_count_q <= frame_count_d;
         clr_cnt_q     <= clr_cnt_d;
         drop_err_q    <= drop_err_d;
      end
   end

   // Writes and clears always target the back bank, using front_sel before any swap this edge.
   assign mem_we    = (state_q == ST_CLEAR) | (wr_en & wr_ready);
   assign mem_addr  = (state_q == ST_CLEAR) ? clr_cnt_q : {wr_col, wr_row};
   assign mem_wdata = (state_q == ST_CLEAR) ? CLEAR_COLOR : wr_data;
   assign rd_addr   = {rd_col, rd_row};

   always_ff @(posedge clk) begin
      if (mem_we) begin
         if (front_sel_q) bank0[mem_addr] <= mem_wdata;
         else             bank1[mem_addr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= rd_en;
         if (rd_en) rd_data_q <= front_sel_q ? bank1[rd_addr] : bank0[rd_addr];
      end
   end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
Double-buffered pixel store. It sits between the ray tracer host (writer) and the vga scan-out (reader), replacing the single dual-port pixel RAM. The tracer fills the back bank while vga reads the front bank. Banks swap only at a vga frame boundary, after the tracer declares the frame complete, so no frame is ever torn. Grid size and pixel width are parametrised, and the new back bank can optionally be auto-cleared after each swap.

Parameters:
COL_BITS, 7, column block-address width (128 columns)
ROW_BITS, 6, row block-address width (64 rows)
PIX_W, 12, pixel width, packed {r[3:0],g[3:0],b[3:0]} at default
CLEAR_ON_SWAP, 1, 1 = clear the new back bank after a swap; 0 = no clear
CLEAR_COLOR, 12'h000, value written during a clear (PIX_W bits)

Ports:
clk  in  1  single clock for all logic
rst  in  1  reset, asynchronous and active-high
wr_en  in  1  write strobe from the tracer
wr_col  in  COL_BITS  write column
wr_row  in  ROW_BITS  write row
wr_data  in  PIX_W  write pixel
wr_frame_done  in  1  one-cycle pulse: back frame complete
wr_ready  out  1  writes accepted this cycle
rd_en  in  1  read strobe from vga
rd_col  in  COL_BITS  read column
rd_row  in  ROW_BITS  read row
rd_data  out  PIX_W  read pixel
rd_valid  out  1  rd_data valid
frame_sync  in  1  one-cycle pulse from vga at vertical blank start
front_sel  out  1  index of the bank currently displayed
frame_count  out  16  completed swaps, wraps at 16'hFFFF->0
drop_err  out  1  sticky: a write arrived while wr_ready=0

Behaviour:
- Storage: two banks, each 2^(COL_BITS+ROW_BITS) x PIX_W. Address = {col,row}, col in the MSBs.
- Reset values (asynchronous): front_sel=0, frame_count=0, rd_data=0, rd_valid=0, drop_err=0. State is WRITE, so wr_ready=1. Bank contents are undefined after reset; no clear is performed at reset.
- Read path:
  - Synchronous read from bank front_sel, one-cycle latency.
  - rd_valid is rd_en delayed by one cycle. rd_data holds its value when rd_valid=0.
  - The bank is selected by the front_sel value in the cycle rd_en is sampled. A read issued in the swap cycle therefore returns the old front bank.
- Write path: a write lands in bank ~front_sel only when wr_en=1 and wr_ready=1.
- FSM states:
  - WRITE: wr_ready=1.
    - wr_frame_done=1 and frame_sync=0 -> PENDING.
    - wr_frame_done=1 and frame_sync=1 in the same cycle -> swap immediately. Any write in that cycle commits to the old back bank first.
  - PENDING: wr_ready=0. Waits for frame_sync. On frame_sync -> swap. A further wr_frame_done here is ignored.
  - Swap action:
    - front_sel toggles and frame_count increments, both in the same clock edge.
    - Next state is CLEAR if CLEAR_ON_SWAP=1, otherwise WRITE.
  - CLEAR: wr_ready=0.
    - An internal counter walks addresses 0 .. 2^(COL_BITS+ROW_BITS)-1, one per cycle, writing CLEAR_COLOR to the new back bank.
    - After the last address -> WRITE. Clear takes exactly 2^(COL_BITS+ROW_BITS) cycles.
    - frame_sync during CLEAR is ignored.
    - wr_frame_done during CLEAR is ignored and sets drop_err.
- drop_err is set by wr_en=1 with wr_ready=0. It clears only on rst.
- frame_sync with no pending frame: no swap; front_sel is unchanged.
- Reset mid-operation (PENDING or CLEAR) returns to WRITE with front_sel=0. A partial clear is abandoned.

Test Plan:
Bench parameters: COL_BITS=2, ROW_BITS=2, PIX_W=12, CLEAR_COLOR=12'h00F.
1. Reset, then write addr (1,2)=12'hABC, then wr_frame_done and frame_sync in separate cycles -> front_sel=1, frame_count=1. After the 16-cycle clear, reading (1,2) returns 12'hABC with rd_valid one cycle after rd_en.
2. After scenario 1, read back-bank contents by swapping an empty frame (wr_frame_done then frame_sync) -> every address reads 12'h00F.
3. Pulse wr_frame_done and frame_sync in the same cycle, with a write of 12'h123 to (0,0) in that cycle -> the swap happens that edge, and (0,0) reads 12'h123 from the new front bank.
4. While PENDING, assert wr_en with 12'h555 -> wr_ready=0, the write is dropped, drop_err=1 and stays 1 until rst.
5. Pulse frame_sync with no pending frame ×3 -> front_sel unchanged, frame_count unchanged.
6. Assert rst 5 cycles into CLEAR -> front_sel=0, frame_count=0, wr_ready=1 asynchronously. Normal writes work after rst deasserts.
